seq_multiplier: RTL

Parametrised multi-cycle shift-add multiplier for the MiniAlu execute stage. It computes the full 2×WIDTH-bit product of two WIDTH-bit operands in signed or unsigned mode, using a start/busy/done handshake. It replaces the single-cycle combinational multiplier array, trading latency for area. It also flags results that do not fit a WIDTH-bit register, so the ALU can store the low half and report overflow.

---
 rtl/seq_multiplier_if.sv | 18 +
 rtl/seq_multiplier.sv | 110 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier.
// The master drives the requests and the slave (the multiplier) returns the results.
interface seq_multiplier_if #(parameter int WIDTH = 16);
  logic                 iStart;
  logic                 iSigned;
  logic [WIDTH-1:0]     iA;
  logic [WIDTH-1:0]     iB;
  logic                 iFlush;
  logic                 oBusy;
  logic                 oDone;
  logic [2*WIDTH-1:0]   oProduct;
  logic                 oOverflow;

  modport master (output iStart, iSigned, iA, iB, iFlush,
                  input  oBusy, oDone, oProduct, oOverflow);
  modport slave  (input  iStart, iSigned, iA, iB, iFlush,
                  output oBusy, oDone, oProduct, oOverflow);
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier that handles signed and unsigned operands.
// It multiplies the operand magnitudes, then restores the sign in one fixup cycle.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  seq_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_PW = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              sgn_q, sgn_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              ovf_q, ovf_d;

  // Unsigned W-bit magnitudes are enough: |-2^(W-1)| = 2^(W-1) fits when read unsigned.
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [PW-1:0]     res;
  logic [WIDTH:0]    res_hi_s;
  logic              res_ovf;

  always_comb begin
    a_mag    = (bus.iSigned && bus.iA[WIDTH-1]) ? (~bus.iA + ONE_W) : bus.iA;
    b_mag    = (bus.iSigned && bus.iB[WIDTH-1]) ? (~bus.iB + ONE_W) : bus.iB;
    res      = neg_q ? (~acc_q + ONE_PW) : acc_q;
    res_hi_s = res[PW-1:WIDTH-1];
    res_ovf  = sgn_q ? !((res_hi_s == '0) || (res_hi_s == '1))
                     : (res[PW-1:WIDTH] != '0);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    if (bus.iFlush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.iStart) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          sgn_d    = bus.iSigned;
          neg_d    = bus.iSigned & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
          state_d  = RUN;
        end
        RUN: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          prod_d  = res;
          ovf_d   = res_ovf;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.oBusy     = (state_q != IDLE);
  assign bus.oDone     = (state_q == DONE);
  assign bus.oProduct  = prod_q;
  assign bus.oOverflow = ovf_q;
endmodule
